s_coef_bank: RTL

- Parametrised successor to the S coefficient-vector RAM used by the PEA actor.
- Stores num_vectors polynomial coefficient vectors of up to max_degree+1 words each.
- Adds a registered read with a q_en pulse and a write acknowledge (wr_suc).
- Tracks a degree and valid flag per vector, returns 0 for unwritten or above-degree coefficients, and provides a sequential vector-clear FSM.

---
 rtl/s_coef_bank.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/s_coef_bank.sv
// s_coef_bank: bank of num_vectors polynomial coefficient vectors, max_degree+1 words each.
// Each vector has a valid flag and a degree; coefficients of an invalid vector, or above
// its degree, read back as 0. A sequential FSM zeroes one whole vector.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data              write data
//   wr_vector_addr,
//   wr_coef_addr,
//   wr_en             write request; dropped on an illegal address or while busy
//   rd_vector_addr,
//   rd_coef_addr,
//   rd_en             read request, latency 1
//   clr_vector_addr,
//   clr_start         start clearing a vector (ignored while busy or on an illegal address)
//   q, rd_degree      registered read data and degree of the vector read
//   q_en              one-cycle pulse: q/rd_degree updated
//   wr_suc            one-cycle pulse: write committed
//   busy              clear in progress
//   clr_done          one-cycle pulse: clear finished
//   vec_valid         per-vector "holds at least one write" flag
module s_coef_bank #(
  parameter int unsigned word_size   = 16,
  parameter int unsigned num_vectors = 8,
  parameter int unsigned max_degree  = 10,
  localparam int unsigned VW = (num_vectors > 1) ? $clog2(num_vectors) : 1,
  localparam int unsigned CW = (max_degree > 0) ? $clog2(max_degree + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [word_size-1:0]   data,
  input  logic [VW-1:0]          wr_vector_addr,
  input  logic [CW-1:0]          wr_coef_addr,
  input  logic                   wr_en,
  input  logic [VW-1:0]          rd_vector_addr,
  input  logic [CW-1:0]          rd_coef_addr,
  input  logic                   rd_en,
  input  logic [VW-1:0]          clr_vector_addr,
  input  logic                   clr_start,
  output logic [word_size-1:0]   q,
  output logic                   q_en,
  output logic [CW-1:0]          rd_degree,
  output logic                   wr_suc,
  output logic                   busy,
  output logic                   clr_done,
  output logic [num_vectors-1:0] vec_valid
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  // Coefficient storage is deliberately not reset; vec_valid masks stale contents.
  logic [word_size-1:0] mem [num_vectors][max_degree+1];

  logic [CW-1:0]          degree_q [num_vectors];
  logic [CW-1:0]          degree_d [num_vectors];
  logic [num_vectors-1:0] vec_valid_d;

  state_e        state_q;
  logic [VW-1:0] clr_vec_q;
  logic [CW-1:0] cnt_q;

  logic wr_legal, rd_legal, clr_legal;
  logic wr_fire, rd_fire, clr_fire;

  assign wr_legal  = (32'(wr_vector_addr) < num_vectors) && (32'(wr_coef_addr) <= max_degree);
  assign rd_legal  = (32'(rd_vector_addr) < num_vectors) && (32'(rd_coef_addr) <= max_degree);
  assign clr_legal = 32'(clr_vector_addr) < num_vectors;

  assign wr_fire  = wr_en && wr_legal && !busy;
  assign rd_fire  = rd_en && rd_legal;
  assign clr_fire = (state_q == StIdle) && clr_start && clr_legal;

  // Next-state of the per-vector bookkeeping. A clear starting on the same edge as a write
  // to the same vector wins: the vector ends up invalid.
  always_comb begin
    vec_valid_d = vec_valid;
    for (int v = 0; v < int'(num_vectors); v++) begin
      degree_d[v] = degree_q[v];
    end
    if (wr_fire) begin
      vec_valid_d[wr_vector_addr] = 1'b1;
      if (!vec_valid[wr_vector_addr] || (wr_coef_addr > degree_q[wr_vector_addr])) begin
        degree_d[wr_vector_addr] = wr_coef_addr;
      end
    end
    if (clr_fire) begin
      vec_valid_d[clr_vector_addr] = 1'b0;
      degree_d[clr_vector_addr]    = '0;
    end
  end

  // Read data is evaluated against post-write state so a same-edge write is seen (write-first).
  logic [word_size-1:0] rd_word;
  logic [word_size-1:0] q_d;
  logic [CW-1:0]        rd_degree_d;
  logic                 rd_vec_ok;

  always_comb begin
    rd_word = '0;
    if (rd_legal) begin
      rd_word = mem[rd_vector_addr][rd_coef_addr];
    end
    if (wr_fire && (wr_vector_addr == rd_vector_addr) && (wr_coef_addr == rd_coef_addr)) begin
      rd_word = data;
    end
    rd_vec_ok   = vec_valid_d[rd_vector_addr];
    q_d         = (rd_vec_ok && (rd_coef_addr <= degree_d[rd_vector_addr])) ? rd_word : '0;
    rd_degree_d = rd_vec_ok ? degree_d[rd_vector_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_vector_addr][wr_coef_addr] <= data;
    end else if (state_q == StClear) begin
      mem[clr_vec_q][cnt_q] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_valid <= '0;
      for (int v = 0; v < int'(num_vectors); v++) begin
        degree_q[v] <= '0;
      end
      q         <= '0;
      q_en      <= 1'b0;
      rd_degree <= '0;
      wr_suc    <= 1'b0;
    end else begin
      vec_valid <= vec_valid_d;
      degree_q  <= degree_d;
      wr_suc    <= wr_fire;
      q_en      <= rd_fire;
      if (rd_fire) begin
        q         <= q_d;
        rd_degree <= rd_degree_d;
      end
    end
  end

  // Clear FSM: IDLE -> CLEAR (one coefficient per cycle) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clr_vec_q <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clr_fire) begin
            state_q   <= StClear;
            clr_vec_q <= clr_vector_addr;
            cnt_q     <= '0;
            busy      <= 1'b1;
          end
        end
        StClear: begin
          if (32'(cnt_q) == max_degree) begin
            state_q  <= StDone;
            clr_done <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
